// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: bus layout, FU indices and the
// round-robin wrap helper.
package wb_arbiter_pkg;

  localparam int PREG_WIDTH_DEF = 6;
  localparam int ROB_WIDTH_DEF  = 6;
  localparam int RESULT_WIDTH   = 32;
  localparam int NUM_FU         = 3;

  localparam int BUS_WIDTH = 1 + ROB_WIDTH_DEF + PREG_WIDTH_DEF + RESULT_WIDTH;

  // Field positions inside a bus word {valid, rob, rd, result}
  localparam int BUS_RESULT_LO = 0;
  localparam int BUS_RESULT_HI = RESULT_WIDTH - 1;
  localparam int BUS_RD_LO     = RESULT_WIDTH;
  localparam int BUS_RD_HI     = RESULT_WIDTH + PREG_WIDTH_DEF - 1;
  localparam int BUS_ROB_LO    = RESULT_WIDTH + PREG_WIDTH_DEF;
  localparam int BUS_ROB_HI    = RESULT_WIDTH + PREG_WIDTH_DEF + ROB_WIDTH_DEF - 1;
  localparam int BUS_VALID     = BUS_WIDTH - 1;

  localparam logic [1:0] FU_ALU0 = 2'd0;
  localparam logic [1:0] FU_ALU1 = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;

  function automatic logic [1:0] fu_next(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      FU_ALU0: nxt = FU_ALU1;
      FU_ALU1: nxt = FU_MEM;
      FU_MEM:  nxt = FU_ALU0;
      default: nxt = FU_ALU0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-FU result buffer: circular storage with registered count, one push
// and one pop port; push and pop in the same cycle keep the count.
module wb_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= din;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from alu0/alu1/mem and broadcasts up to
// two per cycle on registered buses, round-robin from the rr pointer.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int PREG_WIDTH = PREG_WIDTH_DEF,
  parameter int ROB_WIDTH  = ROB_WIDTH_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [2:0]                                   fu_valid,
  output logic [2:0]                                   fu_ready,
  input  logic [2:0][PREG_WIDTH-1:0]                   fu_rd,
  input  logic [2:0][ROB_WIDTH-1:0]                    fu_rob,
  input  logic [2:0][31:0]                             fu_result,
  output logic [ROB_WIDTH+PREG_WIDTH+RESULT_WIDTH:0]   bus0,
  output logic [ROB_WIDTH+PREG_WIDTH+RESULT_WIDTH:0]   bus1,
  output logic [2:0]                                   fu_release
);

  localparam int EW = ROB_WIDTH + PREG_WIDTH + RESULT_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [EW-1:0] head_s [3];
  logic [CW-1:0] cnt_s  [3];
  logic [2:0]    rdy_s;
  logic [2:0]    nonempty_s;
  logic [2:0]    push_s;
  logic [2:0]    pop_s;

  logic [1:0]    rr_r;
  logic [1:0]    ord0_s, ord1_s, ord2_s;
  logic          g0_v_s, g1_v_s;
  logic [1:0]    g0_idx_s, g1_idx_s;
  logic [1:0]    rr_next_s;
  logic [EW-1:0] b0_head_s, b1_head_s;

  for (genvar i = 0; i < 3; i++) begin : g_fu
    assign rdy_s[i]      = (cnt_s[i] < CW'(FIFO_DEPTH));
    assign nonempty_s[i] = (cnt_s[i] != CW'(0));
    assign push_s[i]     = fu_valid[i] & rdy_s[i];
    assign pop_s[i]      = (g0_v_s && (g0_idx_s == 2'(i))) ||
                           (g1_v_s && (g1_idx_s == 2'(i)));

    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .din   ({fu_rob[i], fu_rd[i], fu_result[i]}),
      .head  (head_s[i]),
      .count (cnt_s[i])
    );
  end

  assign fu_ready = rdy_s;

  // Scan order from rr, then pick the first two non-empty FIFOs in that order
  always_comb begin
    ord0_s   = rr_r;
    ord1_s   = fu_next(rr_r);
    ord2_s   = fu_next(fu_next(rr_r));
    g0_v_s   = 1'b0;
    g1_v_s   = 1'b0;
    g0_idx_s = ord0_s;
    g1_idx_s = ord1_s;
    case ({nonempty_s[ord2_s], nonempty_s[ord1_s], nonempty_s[ord0_s]})
      3'b001: begin g0_v_s = 1'b1; g0_idx_s = ord0_s; end
      3'b010: begin g0_v_s = 1'b1; g0_idx_s = ord1_s; end
      3'b100: begin g0_v_s = 1'b1; g0_idx_s = ord2_s; end
      3'b011, 3'b111: begin
        g0_v_s = 1'b1; g0_idx_s = ord0_s;
        g1_v_s = 1'b1; g1_idx_s = ord1_s;
      end
      3'b101: begin
        g0_v_s = 1'b1; g0_idx_s = ord0_s;
        g1_v_s = 1'b1; g1_idx_s = ord2_s;
      end
      3'b110: begin
        g0_v_s = 1'b1; g0_idx_s = ord1_s;
        g1_v_s = 1'b1; g1_idx_s = ord2_s;
      end
      default: begin g0_v_s = 1'b0; g1_v_s = 1'b0; end
    endcase
    if (g1_v_s) begin
      rr_next_s = fu_next(g1_idx_s);
    end else if (g0_v_s) begin
      rr_next_s = fu_next(g0_idx_s);
    end else begin
      rr_next_s = rr_r;
    end
  end

  // Head muxes for the two granted FIFOs
  always_comb begin
    case (g0_idx_s)
      FU_ALU1: b0_head_s = head_s[1];
      FU_MEM:  b0_head_s = head_s[2];
      default: b0_head_s = head_s[0];
    endcase
    case (g1_idx_s)
      FU_ALU1: b1_head_s = head_s[1];
      FU_MEM:  b1_head_s = head_s[2];
      default: b1_head_s = head_s[0];
    endcase
  end

  // Round-robin pointer, broadcast buses and release pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_r       <= 2'd0;
      bus0       <= '0;
      bus1       <= '0;
      fu_release <= 3'b000;
    end else begin
      rr_r       <= rr_next_s;
      bus0       <= g0_v_s ? {1'b1, b0_head_s} : '0;
      bus1       <= g1_v_s ? {1'b1, b1_head_s} : '0;
      fu_release <= push_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter; a queue-based reference model
// predicts every cycle and a monitor compares it against the DUT.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int PW    = 6;
  localparam int RW    = 6;
  localparam int DEPTH = 2;
  localparam int EW    = RW + PW + 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [2:0]           fu_valid = 3'b000;
  logic [2:0]           fu_ready;
  logic [2:0][PW-1:0]   fu_rd = '0;
  logic [2:0][RW-1:0]   fu_rob = '0;
  logic [2:0][31:0]     fu_result = '0;
  logic [BUS_WIDTH-1:0] bus0, bus1;
  logic [2:0]           fu_release;

  wb_arbiter #(.PREG_WIDTH(PW), .ROB_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_rd(fu_rd), .fu_rob(fu_rob), .fu_result(fu_result),
    .bus0(bus0), .bus1(bus1), .fu_release(fu_release)
  );

  always #5 clk = ~clk;

  typedef logic [EW-1:0] ent_t;
  typedef struct {
    logic       b0v;
    ent_t       b0;
    logic       b1v;
    ent_t       b1;
    logic [2:0] rel;
    logic [2:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  ent_t mq[3][$];
  int   rr_m = 0;
  logic [2:0] acc_m = 3'b000;
  int   acc_total[3] = '{0, 0, 0};

  int errors = 0;
  int checks = 0;

  int   cyc = 0;
  logic fair_on = 1'b0;
  int   gcnt[3] = '{0, 0, 0};
  int   last_g[3] = '{0, 0, 0};
  int   max_gap[3] = '{0, 0, 0};
  int   rel0_cnt = 0;

  int   seq[3] = '{4, 0, 0};
  logic pend[3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: FIFOs as queues, scan order by modulo arithmetic
  always @(posedge clk) begin : model
    exp_t e;
    int g, last, idx;
    e.b0v = 1'b0; e.b0 = '0; e.b1v = 1'b0; e.b1 = '0;
    e.rel = 3'b000; e.rdy = 3'b111;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      rr_m  = 0;
      acc_m = 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) acc_m[k] = fu_valid[k] && (mq[k].size() < DEPTH);
      g = 0; last = 0;
      for (int k = 0; k < 3; k++) begin
        idx = (rr_m + k) % 3;
        if (g < 2 && mq[idx].size() > 0) begin
          if (g == 0) begin e.b0v = 1'b1; e.b0 = mq[idx].pop_front(); end
          else begin e.b1v = 1'b1; e.b1 = mq[idx].pop_front(); end
          last = idx;
          g++;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (acc_m[k]) begin
          mq[k].push_back({fu_rob[k], fu_rd[k], fu_result[k]});
          acc_total[k]++;
        end
      end
      if (g > 0) rr_m = (last + 1) % 3;
      e.rel = acc_m;
      for (int k = 0; k < 3; k++) e.rdy[k] = (mq[k].size() < DEPTH);
    end
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs one step after each edge
  always @(posedge clk) begin : monitor
    exp_t e;
    int f;
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      chk("exp_queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("bus0_valid", 64'(bus0[BUS_VALID]), 64'(e.b0v));
      if (e.b0v) chk("bus0_data", 64'(bus0[BUS_ROB_HI:0]), 64'(e.b0));
      chk("bus1_valid", 64'(bus1[BUS_VALID]), 64'(e.b1v));
      if (e.b1v) chk("bus1_data", 64'(bus1[BUS_ROB_HI:0]), 64'(e.b1));
      chk("fu_release", 64'(fu_release), 64'(e.rel));
      chk("fu_ready", 64'(fu_ready), 64'(e.rdy));
    end
    if (bus0[BUS_VALID] && bus1[BUS_VALID])
      chk("rob_distinct", 64'(bus0[BUS_ROB_HI:BUS_ROB_LO] != bus1[BUS_ROB_HI:BUS_ROB_LO]), 64'd1);
    if (fu_release[0] === 1'b1) rel0_cnt++;
    for (int b = 0; b < 2; b++) begin
      if ((b == 0) ? bus0[BUS_VALID] : bus1[BUS_VALID]) begin
        f = int'((b == 0) ? bus0[BUS_ROB_HI -: 2] : bus1[BUS_ROB_HI -: 2]);
        if (f < 3) begin
          if (fair_on) begin
            gcnt[f]++;
            if (cyc - last_g[f] > max_gap[f]) max_gap[f] = cyc - last_g[f];
          end
          last_g[f] = cyc;
        end
      end
    end
  end

  // One stimulus cycle: retire accepted items, offer new ones where wanted
  task automatic drive(input logic [2:0] want);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (acc_m[k]) pend[k] = 1'b0;
      if (!pend[k] && want[k]) begin
        fu_rob[k]    = RW'((k << 4) | (seq[k] & 15));
        fu_rd[k]     = PW'($urandom);
        fu_result[k] = $urandom;
        seq[k]++;
        pend[k] = 1'b1;
      end
      fu_valid[k] = pend[k] & want[k];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fu_valid = 3'b000;
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
    @(negedge clk);
    chk("rst_bus0_valid", 64'(bus0[BUS_VALID]), 64'd0);
    chk("rst_bus1_valid", 64'(bus1[BUS_VALID]), 64'd0);
    chk("rst_fu_ready", 64'(fu_ready), 64'h7);
    chk("rst_fu_release", 64'(fu_release), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [EW:0] want032;
    int rel_start, bp_start, acc_at_low;
    logic saw_low;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(fu_ready), 64'h7);
    chk("reset_bus0_valid", 64'(bus0[BUS_VALID]), 64'd0);
    rst_n = 1'b1;

    // Single alu0 result
    rel_start = rel0_cnt;
    @(negedge clk);
    chk("ready_after_reset", 64'(fu_ready), 64'h7);
    fu_valid = 3'b001; fu_rd[0] = 6'd5; fu_rob[0] = 6'd3; fu_result[0] = 32'd42;
    @(negedge clk);
    fu_valid = 3'b000;
    @(negedge clk);
    want032 = {1'b1, 6'd3, 6'd5, 32'd42};
    chk("single_bus0", 64'(bus0), 64'(want032));
    chk("single_bus1_valid", 64'(bus1[BUS_VALID]), 64'd0);
    repeat (3) drive(3'b000);
    chk("single_release_pulses", 64'(rel0_cnt - rel_start), 64'd1);

    // Three-way contention from rr=0
    do_reset();
    drive(3'b111);
    drive(3'b000);
    @(negedge clk);
    chk("c3_t1_bus0_fu", 64'({bus0[BUS_VALID], bus0[BUS_ROB_HI -: 2]}), 64'({1'b1, FU_ALU0}));
    chk("c3_t1_bus1_fu", 64'({bus1[BUS_VALID], bus1[BUS_ROB_HI -: 2]}), 64'({1'b1, FU_ALU1}));
    @(negedge clk);
    chk("c3_t2_bus0_fu", 64'({bus0[BUS_VALID], bus0[BUS_ROB_HI -: 2]}), 64'({1'b1, FU_MEM}));
    chk("c3_t2_bus1_valid", 64'(bus1[BUS_VALID]), 64'd0);
    repeat (3) drive(3'b000);

    // Back-pressure on mem with alu traffic keeping the buses busy
    bp_start = acc_total[2];
    saw_low = 1'b0;
    acc_at_low = -1;
    for (int c = 0; c < 40 && (acc_total[2] - bp_start) < 4; c++) begin
      drive({((acc_total[2] - bp_start) < 4), 2'b11});
      if (!fu_ready[2] && !saw_low) begin
        saw_low = 1'b1;
        acc_at_low = acc_total[2] - bp_start;
      end
    end
    chk("bp_mem_accepts", 64'(acc_total[2] - bp_start), 64'd4);
    chk("bp_ready_dropped", 64'(saw_low), 64'd1);
    chk("bp_accepts_before_drop", 64'(acc_at_low), 64'd2);
    repeat (6) drive(3'b000);

    // Fairness under continuous contention
    repeat (6) drive(3'b111);
    fair_on = 1'b1;
    repeat (30) drive(3'b111);
    fair_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fair_grants_fu%0d", k), 64'(gcnt[k]), 64'd20);
      chk($sformatf("fair_gap_fu%0d", k), 64'(max_gap[k] <= 2), 64'd1);
    end

    // Reset while results are buffered
    repeat (3) drive(3'b111);
    do_reset();
    repeat (4) drive(3'b000);

    // Random traffic
    for (int c = 0; c < 400; c++) drive(3'($urandom_range(0, 7)));
    repeat (8) drive(3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter PREG_WIDTH, default 6, physical destination register tag width.
REQ-002 Parameter ROB_WIDTH, default 6, ROB index width.
REQ-003 Parameter FIFO_DEPTH, default 2, result buffer entries per functional unit.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 fu_valid  input  3  per-FU result valid; index 0=alu0, 1=alu1, 2=mem.
REQ-007 fu_ready  output  3  per-FU result accept; a result is transferred when fu_valid[i] and fu_ready[i] are both high at posedge.
REQ-008 fu_rd  input  3xPREG_WIDTH  per-FU destination physical register.
REQ-009 fu_rob  input  3xROB_WIDTH  per-FU ROB index.
REQ-010 fu_result  input  3x32  per-FU result data.
REQ-011 bus0, bus1  output  BUS_WIDTH each  registered result broadcast buses: {valid, rob, rd, result}, consumed by the reservation station and ROB.
REQ-012 fu_release  output  3  one-cycle pulse per FU when that FU's result is accepted; feeds the FU-availability table.

Function
REQ-013 Each FU has its own FIFO of FIFO_DEPTH entries holding {rob, rd, result}.
REQ-014 fu_ready[i] = 1 exactly when FIFO i count < FIFO_DEPTH, computed from the registered count only. A same-cycle pop does not raise ready.
REQ-015 A transfer pushes into FIFO i at that posedge and drives fu_release[i]=1 for the following cycle.
REQ-016 Each cycle the arbiter scans FIFOs in order rr, rr+1, rr+2 (mod 3). The first non-empty FIFO is granted bus0 and the second non-empty FIFO is granted bus1.
REQ-017 At most one entry pops per FIFO per cycle, and at most two pop in total.
REQ-018 At posedge, each bus register loads its granted FIFO head with valid=1. A bus with no grant loads valid=0, and its other fields are don't-care.
REQ-019 After any grant, rr advances to (index of last granted FU + 1) mod 3. With no grant, rr is unchanged.
REQ-020 Minimum latency: a result accepted at posedge T is visible on a bus after posedge T+1.
REQ-021 FIFO order: results from the same FU appear on the buses in acceptance order.
REQ-022 Push and pop on the same FIFO in the same cycle is legal and leaves the count unchanged.
REQ-023 bus0 and bus1 never carry the same ROB index in the same cycle.
REQ-024 When both buses are valid, the entry from the FU earlier in scan order is on bus0.
REQ-025 Bus outputs change only at posedge, so they are stable for negedge sampling downstream.

Reset
REQ-026 While rst_n=0 at posedge:
- all FIFO counts and pointers = 0
- rr = 0
- bus0 and bus1 valid = 0
- fu_release = 0
REQ-027 A reset mid-operation discards all buffered results, and no partial broadcast occurs after reset.
REQ-028 fu_ready = 3'b111 in the first cycle after reset deasserts.

Structure
REQ-029 The shared constants package holds BUS_WIDTH, the BUS_VALID, BUS_ROB, BUS_RD and BUS_RESULT field ranges, and FU index constants (FU_ALU0=0, FU_ALU1=1, FU_MEM=2).
REQ-030 The per-FU buffer is one sub-module, wb_fifo (parameterised width/depth, push/pop/count/head), instantiated three times.
REQ-031 The arbiter, rr pointer and bus registers reside in wb_arbiter.

Verification
REQ-032 Single result: alu0 sends rd=5, rob=3, result=42 at T. Response: bus0={1,3,5,42} after T+1; bus1 valid=0; fu_release[0] pulses once.
REQ-033 Three-way contention: all FUs valid at T with rr=0. Response: after T+1, bus0=alu0 and bus1=alu1, rr=2. After T+2, bus0=mem, bus1 invalid, rr=0.
REQ-034 Back-pressure: hold mem valid for 4 cycles while the buses are kept busy by alu0/alu1 traffic. Response: fu_ready[2] drops after 2 accepts, no mem result is lost or reordered, and all 4 emerge in order.
REQ-035 Fairness: all three FUs continuously valid for 30 cycles. Response: each FU receives 20 grants, and no FU waits more than 2 cycles between grants.
REQ-036 Reset mid-stream: assert rst_n=0 with 2 entries buffered per FU. Response: the next cycle shows both bus valids=0, fu_ready=111, and no stale result is ever broadcast.
